// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the fetch redirect controller: FSM state encoding,
// default reset / exception addresses and the fetch-group size.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_RUN     = 2'd0,
        FS_DS_PEND = 2'd1,
        FS_JR_WAIT = 2'd2,
        FS_EXC     = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF      = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VECTOR_DEF    = 32'hbfc0_0380;
    localparam logic [31:0] FETCH_GROUP_BYTES = 32'd8;

endpackage

// File: rtl/fetch_target_align.sv
// fetch_target_align
// Splits a redirect target into the 8-byte fetch-group address it lands in,
// whether slot 0 of that group must be squashed (target is the slot-1 word),
// and whether the target is not word aligned.
// Ports:
//   i_target       in  32  redirect target
//   o_pc_aligned   out 32  target rounded down to a fetch group
//   o_kill_slot0   out 1   target points at slot 1
//   o_misalign     out 1   target[1:0] != 0
module fetch_target_align (
    input  logic [31:0] i_target,
    output logic [31:0] o_pc_aligned,
    output logic        o_kill_slot0,
    output logic        o_misalign
);

    assign o_pc_aligned = {i_target[31:3], 3'b000};
    assign o_kill_slot0 = i_target[2];
    assign o_misalign   = |i_target[1:0];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Sequences the fetch-group PC of the dual-issue front end and arbitrates
// interrupts, stalls, branch/jump redirects (with MIPS delay slots) and
// register jumps whose target is still outstanding.
// Optional build macro: FETCH_ERET_EN adds i_eret / i_cp0_epc.
// Ports:
//   i_clk, i_reset (sync, active low)
//   i_stall, i_int, i_br_valid, i_br_slot, i_br_target
//   i_jr_valid, i_jr_data_ok, i_jr_data
//   [i_eret, i_cp0_epc]  only with FETCH_ERET_EN
//   o_pc, o_kill_slot0, o_kill_slot1 (describe the group at o_pc)
//   o_flush_id, o_addr_err, o_state
//
// state      | meaning
// RUN        | sequential fetch, redirects accepted
// DS_PEND    | slot-1 branch: delay-slot group fetched, jump to captured target next
// JR_WAIT    | register jump waiting for its target, fetch squashed
// EXC        | exception vector group fetched, resume sequentially
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_int,
    input  logic        i_br_valid,
    input  logic        i_br_slot,
    input  logic [31:0] i_br_target,
    input  logic        i_jr_valid,
    input  logic        i_jr_data_ok,
    input  logic [31:0] i_jr_data,
`ifdef FETCH_ERET_EN
    input  logic        i_eret,
    input  logic [31:0] i_cp0_epc,
`endif
    output logic [31:0] o_pc,
    output logic        o_kill_slot0,
    output logic        o_kill_slot1,
    output logic        o_flush_id,
    output logic        o_addr_err,
    output logic [1:0]  o_state
);

    fetch_state_e r_state, n_state;
    logic [31:0]  r_pc, n_pc;
    logic [31:0]  r_tgt, n_tgt;
    logic         r_kill0, n_kill0;
    logic         r_kill1, n_kill1;
    logic         r_flush, n_flush;
    logic         r_addr_err, n_addr_err;

    logic [31:0]  w_seq_pc;
    logic [31:0]  w_tgt_base;
    logic [31:0]  w_tgt;
    logic [31:0]  w_tgt_pc;
    logic         w_tgt_kill0;
    logic         w_tgt_mis;
    logic         w_redir;
    logic         v_exc;

    assign w_seq_pc = r_pc + FETCH_GROUP_BYTES;
    assign w_redir  = i_br_valid | (i_jr_valid & i_jr_data_ok);

    // DS_PEND jumps to the captured target, JR_WAIT to the late register
    // value; in RUN a branch takes precedence over a ready jr.
    assign w_tgt_base = (r_state == FS_DS_PEND)                 ? r_tgt     :
                        ((r_state == FS_JR_WAIT) || !i_br_valid) ? i_jr_data :
                                                                   i_br_target;
`ifdef FETCH_ERET_EN
    assign w_tgt = i_eret ? i_cp0_epc : w_tgt_base;
`else
    assign w_tgt = w_tgt_base;
`endif

    fetch_target_align u_align (
        .i_target     (w_tgt),
        .o_pc_aligned (w_tgt_pc),
        .o_kill_slot0 (w_tgt_kill0),
        .o_misalign   (w_tgt_mis)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= FS_RUN;
            r_pc       <= RESET_PC;
            r_tgt      <= '0;
            r_kill0    <= 1'b0;
            r_kill1    <= 1'b0;
            r_flush    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= n_state;
            r_pc       <= n_pc;
            r_tgt      <= n_tgt;
            r_kill0    <= n_kill0;
            r_kill1    <= n_kill1;
            r_flush    <= n_flush;
            r_addr_err <= n_addr_err;
        end
    end

    always_comb begin
        n_state    = r_state;
        n_pc       = r_pc;
        n_tgt      = r_tgt;
        n_kill0    = r_kill0;
        n_kill1    = r_kill1;
        n_flush    = 1'b0;
        n_addr_err = 1'b0;
        v_exc      = 1'b0;

        if (i_int) begin
            v_exc = 1'b1;
`ifdef FETCH_ERET_EN
        end else if (i_eret) begin
            if (w_tgt_mis) begin
                v_exc      = 1'b1;
                n_addr_err = 1'b1;
            end else begin
                n_pc    = w_tgt_pc;
                n_kill0 = w_tgt_kill0;
                n_kill1 = 1'b0;
                n_flush = 1'b1;
                n_state = FS_RUN;
            end
`endif
        end else if (i_stall) begin
            // everything holds; flush/addr_err default low
        end else begin
            case (r_state)
                FS_EXC: begin
                    n_pc    = w_seq_pc;
                    n_kill0 = 1'b0;
                    n_kill1 = 1'b0;
                    n_state = FS_RUN;
                end
                FS_DS_PEND: begin
                    n_pc    = w_tgt_pc;
                    n_kill0 = w_tgt_kill0;
                    n_kill1 = 1'b0;
                    n_state = FS_RUN;
                end
                FS_JR_WAIT: begin
                    if (i_jr_data_ok) begin
                        if (w_tgt_mis) begin
                            v_exc      = 1'b1;
                            n_addr_err = 1'b1;
                        end else begin
                            n_pc    = w_tgt_pc;
                            n_kill0 = w_tgt_kill0;
                            n_kill1 = 1'b0;
                            n_state = FS_RUN;
                        end
                    end else begin
                        n_kill0 = 1'b1;
                        n_kill1 = 1'b1;
                    end
                end
                default: begin
                    if (w_redir) begin
                        if (w_tgt_mis) begin
                            v_exc      = 1'b1;
                            n_addr_err = 1'b1;
                        end else if (!i_br_slot) begin
                            n_pc    = w_tgt_pc;
                            n_kill0 = w_tgt_kill0;
                            n_kill1 = 1'b0;
                        end else begin
                            // delay slot is slot 0 of the next group
                            n_tgt   = w_tgt;
                            n_pc    = w_seq_pc;
                            n_kill0 = 1'b0;
                            n_kill1 = 1'b1;
                            n_state = FS_DS_PEND;
                        end
                    end else if (i_jr_valid) begin
                        n_state = FS_JR_WAIT;
                        n_kill1 = 1'b1;
                        if (i_br_slot) begin
                            n_pc    = w_seq_pc;
                            n_kill0 = 1'b0;
                        end else begin
                            // slot-1 delay slot already fetched; refetch is dead
                            n_kill0 = 1'b1;
                        end
                    end else begin
                        n_pc    = w_seq_pc;
                        n_kill0 = 1'b0;
                        n_kill1 = 1'b0;
                    end
                end
            endcase
        end

        if (v_exc) begin
            n_pc    = EXC_VECTOR;
            n_state = FS_EXC;
            n_kill0 = 1'b0;
            n_kill1 = 1'b0;
            n_flush = 1'b1;
        end
    end

    always_comb begin
        o_pc         = r_pc;
        o_kill_slot0 = r_kill0;
        o_kill_slot1 = r_kill1;
        o_flush_id   = r_flush;
        o_addr_err   = r_addr_err;
        o_state      = r_state;
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        int_req;
    logic        br_valid;
    logic        br_slot;
    logic [31:0] br_target;
    logic        jr_valid;
    logic        jr_data_ok;
    logic [31:0] jr_data;
    logic        eret;
    logic [31:0] cp0_epc;
    logic [31:0] pc;
    logic        kill0;
    logic        kill1;
    logic        flush_id;
    logic        addr_err;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_redirect_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_stall      (stall),
        .i_int        (int_req),
        .i_br_valid   (br_valid),
        .i_br_slot    (br_slot),
        .i_br_target  (br_target),
        .i_jr_valid   (jr_valid),
        .i_jr_data_ok (jr_data_ok),
        .i_jr_data    (jr_data),
`ifdef FETCH_ERET_EN
        .i_eret       (eret),
        .i_cp0_epc    (cp0_epc),
`endif
        .o_pc         (pc),
        .o_kill_slot0 (kill0),
        .o_kill_slot1 (kill1),
        .o_flush_id   (flush_id),
        .o_addr_err   (addr_err),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // redirects must never arrive while ID is squashed
    always @(posedge clk) begin
        if (reset && (state == 2'd1 || state == 2'd2))
            assert (!(br_valid || jr_valid))
                else $error("redirect presented while state=%0d", state);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grp(input string tag, input logic [31:0] e_pc, input logic e_k0,
                             input logic e_k1, input logic [1:0] e_st, input logic e_fl);
        check_val({tag, ".pc"},    pc,       e_pc);
        check_val({tag, ".k0"},    32'(kill0),    32'(e_k0));
        check_val({tag, ".k1"},    32'(kill1),    32'(e_k1));
        check_val({tag, ".state"}, 32'(state),    32'(e_st));
        check_val({tag, ".flush"}, 32'(flush_id), 32'(e_fl));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; int_req = 1'b0;
        br_valid = 1'b0; br_slot = 1'b0; br_target = '0;
        jr_valid = 1'b0; jr_data_ok = 1'b0; jr_data = '0;
        eret = 1'b0; cp0_epc = '0;

        step(); step();
        check_grp("reset", 32'hbfc0_0000, 0, 0, 2'd0, 0);
        check_val("reset.aerr", 32'(addr_err), 32'd0);

        reset = 1'b1;
        step(); check_grp("seq1", 32'hbfc0_0008, 0, 0, 2'd0, 0);
        step(); check_grp("seq2", 32'hbfc0_0010, 0, 0, 2'd0, 0);

        br_valid = 1'b1; br_slot = 1'b0; br_target = 32'hbfc0_0104;
        step(); br_valid = 1'b0;
        check_grp("br_s0", 32'hbfc0_0100, 1, 0, 2'd0, 0);
        step(); check_grp("br_s0_seq", 32'hbfc0_0108, 0, 0, 2'd0, 0);

        br_valid = 1'b1; br_slot = 1'b0; br_target = 32'hbfc0_0020;
        step(); br_valid = 1'b0;
        check_grp("br_s0_b", 32'hbfc0_0020, 0, 0, 2'd0, 0);

        br_valid = 1'b1; br_slot = 1'b1; br_target = 32'hbfc0_0200;
        step(); br_valid = 1'b0;
        check_grp("br_s1_ds", 32'hbfc0_0028, 0, 1, 2'd1, 0);
        step(); check_grp("br_s1_tgt", 32'hbfc0_0200, 0, 0, 2'd0, 0);

        stall = 1'b1;
        step(); check_grp("stall_hold", 32'hbfc0_0200, 0, 0, 2'd0, 0);
        stall = 1'b0;

        jr_valid = 1'b1; br_slot = 1'b0; jr_data_ok = 1'b0;
        step(); jr_valid = 1'b0;
        check_grp("jrw0", 32'hbfc0_0200, 1, 1, 2'd2, 0);
        for (int i = 1; i < 3; i++) begin
            step(); check_grp($sformatf("jrw%0d", i), 32'hbfc0_0200, 1, 1, 2'd2, 0);
        end
        jr_data_ok = 1'b1; jr_data = 32'h8000_1000;
        step(); jr_data_ok = 1'b0;
        check_grp("jr_go", 32'h8000_1000, 0, 0, 2'd0, 0);

        jr_valid = 1'b1; br_slot = 1'b1;
        step(); jr_valid = 1'b0; br_slot = 1'b0;
        check_grp("jr_s1_ds", 32'h8000_1008, 0, 1, 2'd2, 0);
        step(); check_grp("jr_s1_wait", 32'h8000_1008, 1, 1, 2'd2, 0);
        int_req = 1'b1;
        step(); int_req = 1'b0;
        check_grp("int_jrw", 32'hbfc0_0380, 0, 0, 2'd3, 1);
        step(); check_grp("exc_exit", 32'hbfc0_0388, 0, 0, 2'd0, 0);

        stall = 1'b1; int_req = 1'b1;
        step(); int_req = 1'b0;
        check_grp("int_stall", 32'hbfc0_0380, 0, 0, 2'd3, 1);
        step(); check_grp("exc_stall", 32'hbfc0_0380, 0, 0, 2'd3, 0);
        stall = 1'b0;
        step(); check_grp("exc_exit2", 32'hbfc0_0388, 0, 0, 2'd0, 0);

        br_valid = 1'b1; br_slot = 1'b0; br_target = 32'hbfc0_0102;
        step(); br_valid = 1'b0;
        check_grp("mis", 32'hbfc0_0380, 0, 0, 2'd3, 1);
        check_val("mis.aerr", 32'(addr_err), 32'd1);
        step();
        check_val("mis.aerr_pulse", 32'(addr_err), 32'd0);
        check_val("mis.exit", pc, 32'hbfc0_0388);

        br_valid = 1'b1; br_slot = 1'b0; br_target = 32'hffff_fff8;
        step(); br_valid = 1'b0;
        check_grp("top", 32'hffff_fff8, 0, 0, 2'd0, 0);
        step(); check_grp("wrap", 32'h0000_0000, 0, 0, 2'd0, 0);

`ifdef FETCH_ERET_EN
        eret = 1'b1; cp0_epc = 32'hbfc0_0014;
        step(); eret = 1'b0;
        check_grp("eret", 32'hbfc0_0010, 1, 0, 2'd0, 1);
        eret = 1'b1; cp0_epc = 32'hbfc0_0016;
        step(); eret = 1'b0;
        check_grp("eret_mis", 32'hbfc0_0380, 0, 0, 2'd3, 1);
        check_val("eret_mis.aerr", 32'(addr_err), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
